// File: rtl/kim_pip_pkg.sv
// Shared types and helpers for the pipelined N-to-1 selector and its skid buffer.
package kim_pip_pkg;

    // Width of the saturating illegal-select counter, independent of the data path.
    localparam int ERR_CNT_WIDTH = 8;

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    // An index is legal when it addresses one of the populated inputs (unsigned compare).
    function automatic logic idx_legal(input logic [31:0] idx, input int unsigned count);
        return idx < count;
    endfunction

endpackage

// File: rtl/kim_skid_buf2.sv
// Generic 2-entry valid/ready skid buffer. The main entry drives the output;
// the skid entry absorbs the one transfer that arrives while the consumer stalls.
// in_ready is registered so the upstream ready path carries no combinational
// dependency on out_ready.
module kim_skid_buf2
    import kim_pip_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    buf_state_t       state;
    buf_state_t       state_next;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             ready_reg;
    logic             push;
    logic             pop;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign push = in_valid && ready_reg;
    assign pop  = (state != BUF_EMPTY) && out_ready;

    // Next-state and register-load decisions for the occupancy FSM.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (push) begin
                    load_main_in = 1'b1;
                    state_next   = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (push && !pop) begin
                    load_skid  = 1'b1;
                    state_next = BUF_TWO;
                end else if (push && pop) begin
                    load_main_in = 1'b1;
                end else if (pop) begin
                    state_next = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    load_main_skid = 1'b1;
                    state_next     = BUF_ONE;
                end
            end
            default: begin
                state_next = BUF_EMPTY;
            end
        endcase
    end

    // Occupancy state and the registered ready (low exactly while full).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BUF_EMPTY;
            ready_reg <= 1'b1;
        end else begin
            state     <= state_next;
            ready_reg <= (state_next != BUF_TWO);
        end
    end

    // Payload registers; cleared on reset so the output reads zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
            skid_data <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

    assign in_ready  = ready_reg;
    assign out_valid = (state != BUF_EMPTY);
    assign out_data  = main_data;

endmodule

// File: rtl/kim_mux_nto1_pipe.sv
// Parametrised N-to-1 selector with a registered valid/ready stage.
// The select is resolved at the handshake (illegal indices fall back to the
// last legal result or zero), then the resolved word enters a 2-entry skid
// buffer so the select path is retimed without losing throughput.
// NUM_INPUTS is intended to lie in 2..16.
module kim_mux_nto1_pipe
    import kim_pip_pkg::*;
#(
    parameter  int MUX_DATA_WIDTH  = 32,
    parameter  int NUM_INPUTS      = 4,
    parameter  int HOLD_ON_INVALID = 1,
    localparam int SEL_WIDTH       = $clog2(NUM_INPUTS)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [SEL_WIDTH-1:0]                 sel,
    input  logic [NUM_INPUTS*MUX_DATA_WIDTH-1:0] data_in,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [MUX_DATA_WIDTH-1:0]            mux_out,
    output logic                                 sel_err,
    output logic [ERR_CNT_WIDTH-1:0]             err_cnt,
    input  logic                                 err_clr
);

    logic                      push;
    logic                      legal;
    logic [MUX_DATA_WIDTH-1:0] picked;
    logic [MUX_DATA_WIDTH-1:0] resolved;
    logic [MUX_DATA_WIDTH-1:0] last_good;

    assign push  = in_valid && in_ready;
    assign legal = idx_legal(32'(sel), NUM_INPUTS);

    // Select by comparing against every populated index so an out-of-range
    // sel never indexes past data_in and picked stays X-free.
    always_comb begin
        picked = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (sel == SEL_WIDTH'(k)) begin
                picked = data_in[k*MUX_DATA_WIDTH +: MUX_DATA_WIDTH];
            end
        end
    end

    // Illegal selects fall back to the last legal word or to zero.
    always_comb begin
        if (legal) begin
            resolved = picked;
        end else if (HOLD_ON_INVALID != 0) begin
            resolved = last_good;
        end else begin
            resolved = '0;
        end
    end

    // Remember the most recent legally selected word for hold-on-invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_good <= '0;
        end else if (push && legal) begin
            last_good <= picked;
        end
    end

    // Pulse sel_err the cycle after an illegal select is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= push && !legal;
        end
    end

    // Saturating illegal-select counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (push && !legal && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    kim_skid_buf2 #(
        .WIDTH(MUX_DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (resolved),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (mux_out)
    );

endmodule

// File: tb/tb_kim_mux_nto1_pipe.sv
// Bench for kim_mux_nto1_pipe: two instances (hold and zero fallback) with
// five inputs, driven in lockstep and compared against a queue-based model.
module tb_kim_mux_nto1_pipe;

    localparam int W  = 32;
    localparam int N  = 5;
    localparam int SW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [SW-1:0]  sel = '0;
    logic [N*W-1:0] data_in = '0;
    logic           out_ready = 1'b0;
    logic           err_clr = 1'b0;

    logic           h_in_ready, h_out_valid, h_sel_err;
    logic [W-1:0]   h_mux_out;
    logic [7:0]     h_err_cnt;
    logic           z_in_ready, z_out_valid, z_sel_err;
    logic [W-1:0]   z_mux_out;
    logic [7:0]     z_err_cnt;

    always #5 clk = ~clk;

    kim_mux_nto1_pipe #(.MUX_DATA_WIDTH(W), .NUM_INPUTS(N), .HOLD_ON_INVALID(1)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(h_in_ready),
        .sel(sel), .data_in(data_in), .out_valid(h_out_valid), .out_ready(out_ready),
        .mux_out(h_mux_out), .sel_err(h_sel_err), .err_cnt(h_err_cnt), .err_clr(err_clr)
    );

    kim_mux_nto1_pipe #(.MUX_DATA_WIDTH(W), .NUM_INPUTS(N), .HOLD_ON_INVALID(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
        .sel(sel), .data_in(data_in), .out_valid(z_out_valid), .out_ready(out_ready),
        .mux_out(z_mux_out), .sel_err(z_sel_err), .err_cnt(z_err_cnt), .err_clr(err_clr)
    );

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] qh[$];
    logic [W-1:0] qz[$];
    logic [W-1:0] last_good = '0;
    int           err_model = 0;
    logic         err_pulse = 1'b0;
    int           n_pushed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic check_outputs();
        check_val("h_out_valid", 32'(h_out_valid), 32'(qh.size() > 0));
        check_val("z_out_valid", 32'(z_out_valid), 32'(qz.size() > 0));
        check_val("h_in_ready", 32'(h_in_ready), 32'(qh.size() < 2));
        check_val("z_in_ready", 32'(z_in_ready), 32'(qz.size() < 2));
        if (qh.size() > 0) check_val("h_mux_out", h_mux_out, qh[0]);
        if (qz.size() > 0) check_val("z_mux_out", z_mux_out, qz[0]);
        check_val("h_mux_known", 32'($isunknown(h_mux_out)), 32'd0);
        check_val("z_mux_known", 32'($isunknown(z_mux_out)), 32'd0);
        check_val("h_sel_err", 32'(h_sel_err), 32'(err_pulse));
        check_val("z_sel_err", 32'(z_sel_err), 32'(err_pulse));
        check_val("h_err_cnt", 32'(h_err_cnt), 32'(err_model));
        check_val("z_err_cnt", 32'(z_err_cnt), 32'(err_model));
    endtask

    // Drive one cycle of inputs (called at a negedge), advance the model, check after the edge.
    task automatic step(input logic v, input logic [SW-1:0] s, input logic [N*W-1:0] d,
                        input logic ordy, input logic clr);
        logic         push;
        logic         pop;
        logic         legal;
        logic [W-1:0] val_h;
        logic [W-1:0] val_z;
        in_valid  = v;
        sel       = s;
        data_in   = d;
        out_ready = ordy;
        err_clr   = clr;
        push  = v && (qh.size() < 2);
        pop   = (qh.size() > 0) && ordy;
        legal = (int'(s) < N);
        if (pop) begin
            void'(qh.pop_front());
            void'(qz.pop_front());
        end
        if (push) begin
            if (legal) begin
                val_h     = d[int'(s)*W +: W];
                val_z     = val_h;
                last_good = val_h;
            end else begin
                val_h = last_good;
                val_z = '0;
            end
            qh.push_back(val_h);
            qz.push_back(val_z);
            n_pushed++;
        end
        err_pulse = push && !legal;
        if (clr) err_model = 0;
        else if (push && !legal && err_model < 255) err_model++;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = $urandom;
        return d;
    endfunction

    initial begin
        logic [N*W-1:0] d;
        int             start;
        int             cycles;

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs();
        check_val("rst_mux_out", h_mux_out, 32'd0);
        check_val("rst_in_ready", 32'(h_in_ready), 32'd1);
        rst_n = 1'b1;

        // Back-to-back legal selects with a free-running consumer
        d = '0;
        for (int k = 0; k < 4; k++) d[k*W +: W] = 32'h1000_0000 + k;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, SW'(k), d, 1'b1, 1'b0);
            check_val("seq_mux_out", h_mux_out, 32'h1000_0000 + k);
            check_val("seq_in_ready", 32'(h_in_ready), 32'd1);
        end
        step(1'b0, '0, d, 1'b1, 1'b0);

        // Back-pressure fills the skid entry
        d = rand_data();
        d[0*W +: W] = 32'hAAAA_0001;
        step(1'b1, 3'd0, d, 1'b0, 1'b0);
        d[0*W +: W] = 32'hBBBB_0002;
        step(1'b1, 3'd0, d, 1'b0, 1'b0);
        check_val("bp_in_ready", 32'(h_in_ready), 32'd0);
        check_val("bp_mux_hold", h_mux_out, 32'hAAAA_0001);
        step(1'b1, 3'd0, d, 1'b0, 1'b0);
        check_val("bp_mux_hold2", h_mux_out, 32'hAAAA_0001);
        step(1'b0, 3'd0, d, 1'b1, 1'b0);
        check_val("bp_next_b", h_mux_out, 32'hBBBB_0002);
        check_val("bp_ready_back", 32'(h_in_ready), 32'd1);
        step(1'b0, 3'd0, d, 1'b1, 1'b0);

        // Illegal select: hold vs zero fallback
        d = rand_data();
        d[1*W +: W] = 32'h55;
        step(1'b1, 3'd1, d, 1'b1, 1'b0);
        step(1'b1, 3'd5, d, 1'b1, 1'b0);
        check_val("ill_hold_out", h_mux_out, 32'h55);
        check_val("ill_zero_out", z_mux_out, 32'h0);
        check_val("ill_sel_err", 32'(h_sel_err), 32'd1);
        check_val("ill_err_cnt", 32'(h_err_cnt), 32'd1);
        step(1'b0, 3'd0, d, 1'b1, 1'b0);
        check_val("ill_pulse_end", 32'(h_sel_err), 32'd0);

        // Counter saturation, then clear beating a same-cycle increment
        for (int i = 0; i < 260; i++) step(1'b1, 3'd6, rand_data(), 1'b1, 1'b0);
        check_val("sat_err_cnt", 32'(h_err_cnt), 32'd255);
        step(1'b1, 3'd7, rand_data(), 1'b1, 1'b1);
        check_val("clr_err_cnt", 32'(h_err_cnt), 32'd0);
        check_val("clr_sel_err", 32'(h_sel_err), 32'd1);
        step(1'b0, 3'd0, d, 1'b1, 1'b0);

        // Asynchronous reset while the buffer is full
        step(1'b1, 3'd3, rand_data(), 1'b0, 1'b0);
        step(1'b1, 3'd4, rand_data(), 1'b0, 1'b0);
        check_val("full_in_ready", 32'(h_in_ready), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        qh.delete();
        qz.delete();
        last_good = '0;
        err_model = 0;
        err_pulse = 1'b0;
        check_val("arst_out_valid", 32'(h_out_valid), 32'd0);
        check_val("arst_mux_out", h_mux_out, 32'd0);
        check_val("arst_in_ready", 32'(h_in_ready), 32'd1);
        check_val("arst_z_mux_out", z_mux_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d = rand_data();
        d[2*W +: W] = 32'hDEAD_BEEF;
        step(1'b1, 3'd2, d, 1'b1, 1'b0);
        check_val("post_rst_valid", 32'(h_out_valid), 32'd1);
        check_val("post_rst_mux", h_mux_out, 32'hDEAD_BEEF);
        step(1'b0, 3'd0, d, 1'b1, 1'b0);

        // Random traffic at 50% valid/ready density
        start  = n_pushed;
        cycles = 0;
        while ((n_pushed - start) < 10000 && cycles < 60000) begin
            step(1'($urandom_range(0, 1)), SW'($urandom_range(0, 7)), rand_data(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
            cycles++;
        end
        check_val("rand_count", 32'(n_pushed - start), 32'd10000);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        check_val("drain_valid", 32'(h_out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
